// File: rtl/usb3_ep_writer.sv
// usb3_ep_writer: packs a 32-bit beat stream into a USB3 endpoint buffer and commits each packet.
// Ports: local_clk/reset_n (async active-low); s_data/s_valid/s_ready/s_last/s_last_bytes beat input;
// buf_in_addr/buf_in_data/buf_in_wren buffer write port; buf_in_ready buffer free;
// buf_in_commit/buf_in_commit_len/buf_in_commit_ack four-phase commit handshake; pkt_count commits done.
// Optional macro USB3_EP_WRITER_TIMEOUT_EN: flush a partial packet after TIMEOUT_CYCLES idle cycles.
module usb3_ep_writer #(
    parameter int MAX_WORDS      = 256,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic        local_clk,
    input  logic        reset_n,
    input  logic [31:0] s_data,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic        s_last,
    input  logic [1:0]  s_last_bytes,
    output logic [8:0]  buf_in_addr,
    output logic [31:0] buf_in_data,
    output logic        buf_in_wren,
    input  logic        buf_in_ready,
    output logic        buf_in_commit,
    output logic [10:0] buf_in_commit_len,
    input  logic        buf_in_commit_ack,
    output logic [15:0] pkt_count
);
    typedef enum logic [1:0] {WAIT_RDY, WRITE, COMMIT, RELEASE} state_t;
    state_t      r_state, w_next;
    logic [8:0]  r_word_cnt, r_addr;
    logic [31:0] r_data;
    logic        r_wren;
    logic [10:0] r_len;
    logic [15:0] r_pkt;
    logic        w_beat, w_full, w_end, w_timeout, w_commit;
    logic [2:0]  w_last_bytes;

    assign w_beat       = s_valid && r_state == WRITE;
    assign w_full       = r_word_cnt == 9'(MAX_WORDS - 1);
    assign w_end        = w_beat && (s_last || w_full);
    assign w_last_bytes = (w_full || s_last_bytes == 2'd0) ? 3'd4 : {1'b0, s_last_bytes};
    // Commit is held off while the final write pulse is still on the bus.
    assign w_commit     = r_state == COMMIT && !r_wren;

`ifdef USB3_EP_WRITER_TIMEOUT_EN
    localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
    logic [IW-1:0] r_idle;
    // A beat in the same cycle always wins over the timeout.
    assign w_timeout = r_state == WRITE && r_word_cnt != 9'd0 && !w_beat && r_idle == IW'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge local_clk or negedge reset_n) begin
        if (!reset_n) r_idle <= '0;
        else r_idle <= (r_state == WRITE && r_word_cnt != 9'd0 && !w_beat && !w_timeout) ? r_idle + 1'b1 : '0;
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            WAIT_RDY: w_next = buf_in_ready ? WRITE : WAIT_RDY;
            WRITE:    w_next = (w_end || w_timeout) ? COMMIT : WRITE;
            COMMIT:   w_next = (w_commit && buf_in_commit_ack) ? RELEASE : COMMIT;
            RELEASE:  w_next = buf_in_commit_ack ? RELEASE : WAIT_RDY;
            default:  w_next = WAIT_RDY;
        endcase
    end

    always_ff @(posedge local_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= WAIT_RDY;
            r_word_cnt <= '0;
            r_addr     <= '0;
            r_data     <= '0;
            r_wren     <= 1'b0;
            r_len      <= '0;
            r_pkt      <= '0;
        end else begin
            r_state <= w_next;
            r_wren  <= w_beat;
            if (w_beat) begin
                r_addr     <= r_word_cnt;
                r_data     <= s_data;
                r_word_cnt <= r_word_cnt + 9'd1;
            end
            if (w_end) r_len <= {r_word_cnt, 2'b00} + 11'(w_last_bytes);
            else if (w_timeout) r_len <= {r_word_cnt, 2'b00};
            if (r_state == RELEASE && !buf_in_commit_ack) begin
                r_word_cnt <= '0;
                r_pkt      <= r_pkt + 16'd1;
            end
        end
    end

    assign s_ready           = r_state == WRITE;
    assign buf_in_commit     = w_commit;
    assign buf_in_addr       = r_addr;
    assign buf_in_data       = r_data;
    assign buf_in_wren       = r_wren;
    assign buf_in_commit_len = r_len;
    assign pkt_count         = r_pkt;
endmodule

// File: tb/tb_usb3_ep_writer.sv
// tb_usb3_ep_writer: directed self-checking bench for usb3_ep_writer.
module tb_usb3_ep_writer;
    logic        local_clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] s_data = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic        s_last = 1'b0;
    logic [1:0]  s_last_bytes = '0;
    logic [8:0]  buf_in_addr;
    logic [31:0] buf_in_data;
    logic        buf_in_wren;
    logic        buf_in_ready = 1'b1;
    logic        buf_in_commit;
    logic [10:0] buf_in_commit_len;
    logic        buf_in_commit_ack = 1'b0;
    logic [15:0] pkt_count;

    int checks = 0;
    int failures = 0;
    logic [8:0]  wa[$];
    logic [31:0] wd[$];
    logic        commit_seen = 1'b0;

    usb3_ep_writer #(.MAX_WORDS(256), .TIMEOUT_CYCLES(16)) dut (
        .local_clk(local_clk), .reset_n(reset_n), .s_data(s_data), .s_valid(s_valid),
        .s_ready(s_ready), .s_last(s_last), .s_last_bytes(s_last_bytes),
        .buf_in_addr(buf_in_addr), .buf_in_data(buf_in_data), .buf_in_wren(buf_in_wren),
        .buf_in_ready(buf_in_ready), .buf_in_commit(buf_in_commit),
        .buf_in_commit_len(buf_in_commit_len), .buf_in_commit_ack(buf_in_commit_ack),
        .pkt_count(pkt_count)
    );

    always #5 local_clk = ~local_clk;

    always @(negedge local_clk) begin
        if (buf_in_wren) begin
            wa.push_back(buf_in_addr);
            wd.push_back(buf_in_data);
        end
        if (buf_in_commit) commit_seen = 1'b1;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, required finish before 1ms");
        $fatal(1, "watchdog");
    end

    task automatic beat(input logic [31:0] d, input logic last, input logic [1:0] lb);
        int n = 0;
        s_valid = 1'b1; s_data = d; s_last = last; s_last_bytes = lb;
        while (!s_ready && n < 100) begin @(negedge local_clk); n++; end
        if (!s_ready) begin
            checks++; failures++;
            $display("FAIL beat_wait: s_ready=0 after 100 cycles, required 1");
        end
        @(negedge local_clk);
    endtask

    task automatic stream(input int n, input int d0, input logic last, input logic [1:0] lb);
        wa.delete(); wd.delete();
        for (int i = 0; i < n; i++) beat(32'(d0 + i), last && i == n - 1, lb);
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    task automatic check_writes(input int n, input int d0);
        int bad = 0;
        checks++;
        if (wa.size() != n) begin failures++; $display("FAIL wren_count: got %0d required %0d", wa.size(), n); end
        for (int i = 0; i < wa.size(); i++) if (wa[i] !== 9'(i) || wd[i] !== 32'(d0 + i)) bad++;
        checks++;
        if (bad != 0) begin failures++; $display("FAIL write_addr_data: %0d bad writes, required 0", bad); end
    endtask

    task automatic finish_commit(input logic [10:0] exp_len, input logic [15:0] exp_pkt);
        int n = 0;
        int bad = 0;
        while (!buf_in_commit && n < 50) begin @(negedge local_clk); n++; end
        checks++;
        if (!buf_in_commit) begin failures++; $display("FAIL commit_rise: commit=0 after 50 cycles, required 1"); end
        checks++;
        if (buf_in_wren !== 1'b0) begin failures++; $display("FAIL commit_after_wren: wren=%b with commit, required 0", buf_in_wren); end
        checks++;
        if (buf_in_commit_len !== exp_len) begin failures++; $display("FAIL commit_len: got %0d required %0d", buf_in_commit_len, exp_len); end
        @(negedge local_clk);
        checks++;
        if (buf_in_commit !== 1'b1 || buf_in_commit_len !== exp_len) begin
            failures++; $display("FAIL commit_hold: commit=%b len=%0d required 1/%0d", buf_in_commit, buf_in_commit_len, exp_len);
        end
        buf_in_commit_ack = 1'b1;
        repeat (4) begin @(negedge local_clk); if (buf_in_commit !== 1'b0 || s_ready !== 1'b0) bad++; end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL release_wait: %0d cycles with commit/s_ready high during ack, required 0", bad); end
        buf_in_commit_ack = 1'b0;
        @(negedge local_clk);
        checks++;
        if (s_ready !== 1'b0 || pkt_count !== exp_pkt) begin
            failures++; $display("FAIL release_done: s_ready=%b pkt=%h required 0/%h", s_ready, pkt_count, exp_pkt);
        end
    endtask

    task automatic test_reset;
        #1;
        checks++;
        if ({s_ready, buf_in_wren, buf_in_commit, buf_in_addr, buf_in_data, buf_in_commit_len, pkt_count} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: rdy=%b wren=%b commit=%b addr=%h data=%h len=%h pkt=%h required all 0",
                     s_ready, buf_in_wren, buf_in_commit, buf_in_addr, buf_in_data, buf_in_commit_len, pkt_count);
        end
        @(negedge local_clk);
        reset_n = 1'b1;
        @(negedge local_clk);
        @(negedge local_clk);
        checks++;
        if (s_ready !== 1'b1) begin failures++; $display("FAIL reset_to_write: s_ready=%b required 1", s_ready); end
    endtask

    task automatic test_full_packet;
        stream(256, 0, 1'b0, 2'd0);
        checks++;
        if (s_ready !== 1'b0) begin failures++; $display("FAIL full_ready_drop: s_ready=%b required 0", s_ready); end
        finish_commit(11'd1024, 16'd1);
        check_writes(256, 0);
    endtask

    task automatic test_short_packet;
        @(negedge local_clk);
        stream(3, 32'h100, 1'b1, 2'd2);
        finish_commit(11'd10, 16'd2);
        check_writes(3, 32'h100);
        @(negedge local_clk);
        checks++;
        if (s_ready !== 1'b1) begin failures++; $display("FAIL short_ready_return: s_ready=%b required 1", s_ready); end
    endtask

    task automatic test_ready_wait;
        int bad = 0;
        stream(1, 32'h55, 1'b1, 2'd0);
        buf_in_ready = 1'b0;
        finish_commit(11'd4, 16'd3);
        repeat (20) begin @(negedge local_clk); if (s_ready !== 1'b0) bad++; end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL ready_hold: s_ready high %0d cycles, required 0", bad); end
        buf_in_ready = 1'b1;
        @(negedge local_clk);
        checks++;
        if (s_ready !== 1'b1) begin failures++; $display("FAIL ready_rise: s_ready=%b required 1", s_ready); end
    endtask

    task automatic test_idle;
        stream(5, 32'h200, 1'b0, 2'd0);
`ifdef USB3_EP_WRITER_TIMEOUT_EN
        finish_commit(11'd20, 16'd4);
        check_writes(5, 32'h200);
`else
        commit_seen = 1'b0;
        repeat (1000) @(negedge local_clk);
        checks++;
        if (commit_seen || s_ready !== 1'b1) begin
            failures++; $display("FAIL idle_hold: commit_seen=%b s_ready=%b required 0/1", commit_seen, s_ready);
        end
        beat(32'h205, 1'b1, 2'd1);
        s_valid = 1'b0; s_last = 1'b0;
        finish_commit(11'd21, 16'd4);
        check_writes(6, 32'h200);
`endif
        @(negedge local_clk);
    endtask

    task automatic test_reset_mid;
        stream(100, 0, 1'b0, 2'd0);
        s_valid = 1'b1;
        reset_n = 1'b0;
        #1;
        checks++;
        if (buf_in_wren !== 1'b0 || buf_in_commit !== 1'b0 || s_ready !== 1'b0 || pkt_count !== 16'd0) begin
            failures++; $display("FAIL mid_reset: wren=%b commit=%b rdy=%b pkt=%h required 0/0/0/0",
                                 buf_in_wren, buf_in_commit, s_ready, pkt_count);
        end
        s_valid = 1'b0;
        @(negedge local_clk);
        reset_n = 1'b1;
        commit_seen = 1'b0;
        repeat (30) @(negedge local_clk);
        checks++;
        if (commit_seen) begin failures++; $display("FAIL mid_reset_no_commit: commit_seen=1 required 0"); end
        stream(1, 32'hABCD, 1'b1, 2'd3);
        finish_commit(11'd3, 16'd1);
        check_writes(1, 32'hABCD);
    endtask

    task automatic test_wrap;
        force dut.r_pkt = 16'hFFFE;
        @(negedge local_clk);
        release dut.r_pkt;
        @(negedge local_clk);
        stream(2, 32'h300, 1'b1, 2'd0);
        finish_commit(11'd8, 16'hFFFF);
        @(negedge local_clk);
        stream(1, 32'h400, 1'b1, 2'd1);
        finish_commit(11'd1, 16'h0000);
    endtask

    initial begin
        test_reset;
        test_full_packet;
        test_short_packet;
        test_ready_wait;
        test_idle;
        test_reset_mid;
        test_wrap;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
